// File: rtl/led_pattern_ctrl_if.sv
// Handshake bundle between the tick/mode source and the LED pattern engine.
// The source drives strobes and mode requests; the engine returns mode_q and led.
interface led_pattern_ctrl_if;
    logic       tick;
    logic [1:0] mode;
    logic       mode_load;
    logic [1:0] mode_q;
    logic       led;

    modport master (
        output tick,
        output mode,
        output mode_load,
        input  mode_q,
        input  led
    );

    modport slave (
        input  tick,
        input  mode,
        input  mode_load,
        output mode_q,
        output led
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED pattern engine: off, on, blink and breathe patterns advanced by tick.
// led is registered one cycle behind the pattern state it reflects.
module led_pattern_ctrl #(
    parameter int PWM_W       = 8,
    parameter int BLINK_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    led_pattern_ctrl_if.slave  bus
);

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_ON    = 3'd1;
    localparam logic [2:0] S_BLINK = 3'd2;
    localparam logic [2:0] S_UP    = 3'd3;
    localparam logic [2:0] S_DN    = 3'd4;

    localparam logic [PWM_W-1:0] DMAX  = {PWM_W{1'b1}};
    localparam logic [7:0]       BLAST = 8'(BLINK_TICKS - 1);

    logic [2:0]       state;
    logic [1:0]       pend;
    logic [1:0]       eff;
    logic [1:0]       cur;
    logic [2:0]       entry;
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] duty;
    logic [7:0]       blink_cnt;
    logic             blink_state;
    logic             led_r;
    logic             led_nxt;

    // A load on a tick cycle is seen by that tick's evaluation.
    assign eff = bus.mode_load ? bus.mode : pend;

    always_comb begin
        cur     = 2'b00;
        entry   = S_OFF;
        led_nxt = 1'b0;
        case (state)
            S_ON:    begin cur = 2'b01; led_nxt = 1'b1;              end
            S_BLINK: begin cur = 2'b10; led_nxt = blink_state;       end
            S_UP,
            S_DN:    begin cur = 2'b11; led_nxt = (pwm_cnt < duty);  end
            default: begin cur = 2'b00; led_nxt = 1'b0;              end
        endcase
        case (eff)
            2'b01:   entry = S_ON;
            2'b10:   entry = S_BLINK;
            2'b11:   entry = S_UP;
            default: entry = S_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_OFF;
            pend        <= 2'b00;
            pwm_cnt     <= '0;
            duty        <= '0;
            blink_cnt   <= '0;
            blink_state <= 1'b0;
            led_r       <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led_r   <= led_nxt;
            if (bus.mode_load)
                pend <= bus.mode;
            if (bus.tick) begin
                if (eff != cur) begin
                    state <= entry;
                    if (eff == 2'b10) begin
                        blink_cnt   <= '0;
                        blink_state <= 1'b1;
                    end
                    if (eff == 2'b11)
                        duty <= '0;
                end else begin
                    case (state)
                        S_BLINK: begin
                            if (blink_cnt == BLAST) begin
                                blink_cnt   <= '0;
                                blink_state <= ~blink_state;
                            end else begin
                                blink_cnt <= blink_cnt + 8'd1;
                            end
                        end
                        // Saturate at the ends and reverse direction.
                        S_UP: begin
                            if (duty == DMAX) state <= S_DN;
                            else              duty  <= duty + 1'b1;
                        end
                        S_DN: begin
                            if (duty == '0) state <= S_UP;
                            else            duty  <= duty - 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.mode_q = cur;
    assign bus.led    = led_r;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed and random bench for led_pattern_ctrl against a behavioural model
// of the pattern rules (integers for counters, mode codes for the pattern).
module tb_led_pattern_ctrl;

    localparam int PW = 8;
    localparam int BT = 4;
    localparam int N  = 1 << PW;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    led_pattern_ctrl_if bus();

    led_pattern_ctrl #(.PWM_W(PW), .BLINK_TICKS(BT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: active pattern as a mode code, breathe direction as a flag.
    int m_act, m_pend, m_duty, m_bcnt, m_pwm;
    bit m_bst, m_up, m_led;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit t, input int m, input bit ld, input bit r);
        int eff;
        if (r) begin
            m_act = 0; m_pend = 0; m_duty = 0; m_bcnt = 0;
            m_pwm = 0; m_bst = 0; m_up = 1; m_led = 0;
            return;
        end
        case (m_act)
            0: m_led = 0;
            1: m_led = 1;
            2: m_led = m_bst;
            default: m_led = (m_pwm < m_duty);
        endcase
        m_pwm = (m_pwm + 1) % N;
        eff = ld ? m : m_pend;
        if (ld) m_pend = m;
        if (!t) return;
        if (eff != m_act) begin
            m_act = eff;
            if (eff == 2) begin m_bcnt = 0; m_bst = 1; end
            if (eff == 3) begin m_duty = 0; m_up = 1; end
        end else if (m_act == 2) begin
            m_bcnt = m_bcnt + 1;
            if (m_bcnt == BT) begin m_bcnt = 0; m_bst = !m_bst; end
        end else if (m_act == 3) begin
            if (m_up) begin
                if (m_duty == N - 1) m_up = 0; else m_duty++;
            end else begin
                if (m_duty == 0) m_up = 1; else m_duty--;
            end
        end
    endtask

    task automatic step(input bit t, input int m, input bit ld, input bit r,
                        input string tag);
        @(negedge clk);
        rst           = r;
        bus.tick      = t;
        bus.mode      = 2'(m);
        bus.mode_load = ld;
        @(posedge clk);
        model_edge(t, m, ld, r);
        #1;
        chk({tag, ".led"}, int'(bus.led), int'(m_led));
        chk({tag, ".mode_q"}, int'(bus.mode_q), m_act);
    endtask

    initial begin
        int ones;
        int guard;
        rst = 1'b1;
        bus.tick = 1'b0;
        bus.mode = 2'b00;
        bus.mode_load = 1'b0;
        model_edge(0, 0, 0, 1);

        step(0, 0, 0, 1, "reset0");
        step(1, 3, 1, 1, "reset1");
        step(1, 0, 0, 0, "tick_pend00");

        step(0, 1, 1, 0, "load_on");
        for (int i = 0; i < 50; i++) step(0, 0, 0, 0, "on_notick");
        step(1, 0, 0, 0, "on_tick");
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, "on_hold");

        step(0, 2, 1, 0, "load_blink");
        for (int k = 0; k < 12; k++) begin
            step(1, 0, 0, 0, "blink_tick");
            for (int i = 0; i < 9; i++) step(0, 0, 0, 0, "blink_gap");
        end
        step(1, 2, 1, 0, "blink_reload");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "blink_gap2");
        step(1, 2, 0, 0, "blink_cont");
        step(1, 3, 1, 0, "to_breathe");
        chk("breathe_duty0", m_duty, 0);
        step(0, 0, 0, 0, "breathe_led0");

        for (int i = 0; i < 300; i++) step(1, 0, 0, 0, "breathe_run");
        guard = 0;
        while (m_duty != 128 && guard < 600) begin
            step(1, 0, 0, 0, "breathe_seek");
            guard++;
        end
        chk("seek128_bound", int'(guard < 600), 1);
        step(0, 0, 0, 0, "pwm_warm");
        step(0, 0, 0, 0, "pwm_warm");
        ones = 0;
        for (int i = 0; i < N; i++) begin
            step(0, 0, 0, 0, "pwm_meas");
            ones += int'(bus.led);
        end
        chk("pwm_ones_at_128", ones, 128);

        guard = 0;
        while (m_duty != 100 && guard < 600) begin
            step(1, 0, 0, 0, "breathe_seek100");
            guard++;
        end
        chk("seek100_bound", int'(guard < 600), 1);
        step(1, 3, 1, 1, "rst_mid_breathe");
        step(1, 0, 0, 0, "tick_after_rst");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, "off_hold");

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) == 0, int'($urandom % 4),
                 ($urandom % 8) == 0, ($urandom % 300) == 0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 Parameter PWM_W, default 8, meaning width of the PWM counter and duty register (range 2..16).
REQ-002 Parameter BLINK_TICKS, default 4, meaning ticks per blink half-period (range 1..255).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tick  input  1  one-cycle strobe, clk-synchronous, from the upstream divider (edge-detected divider output).
REQ-006 mode  input  2  requested pattern: 00 OFF, 01 ON, 10 BLINK, 11 BREATHE.
REQ-007 mode_load  input  1  capture mode into the pending-mode register this cycle.
REQ-008 mode_q  output  2  active mode (mode currently driving led).
REQ-009 led  output  1  registered LED drive.

Function
REQ-010 The block SHALL hold a pending-mode register, written on any cycle with mode_load=1, and an active FSM with states S_OFF, S_ON, S_BLINK, S_UP, S_DN.
REQ-011 The FSM SHALL evaluate mode changes only on tick=1 cycles; on such a cycle the pending mode SHALL be compared with the active mode.
REQ-012 If mode_load=1 and tick=1 in the same cycle, the new mode value SHALL be used for that tick's evaluation (bypass).
REQ-013 Pending equal to active mode SHALL NOT restart the pattern; BREATHE counts as active in both S_UP and S_DN.
REQ-014 Entering S_BLINK SHALL clear blink_cnt to 0 and set blink_state=1.
REQ-015 In S_BLINK, each tick SHALL increment blink_cnt; when blink_cnt = BLINK_TICKS-1 it SHALL wrap to 0 and toggle blink_state on that tick.
REQ-016 Entering BREATHE SHALL set duty=0 and state S_UP.
REQ-017 In S_UP each tick SHALL increment duty; on the tick where duty = 2^PWM_W-1 already, duty SHALL hold and state SHALL become S_DN.
REQ-018 In S_DN each tick SHALL decrement duty; on the tick where duty = 0 already, duty SHALL hold and state SHALL become S_UP.
REQ-019 duty SHALL never wrap; arithmetic is unsigned PWM_W bits.
REQ-020 pwm_cnt (PWM_W bits) SHALL increment every clk cycle in all states and wrap 2^PWM_W-1 -> 0.
REQ-021 Next-led SHALL be: S_OFF 0; S_ON 1; S_BLINK blink_state; S_UP/S_DN (pwm_cnt < duty).
REQ-022 led SHALL be registered: led at edge n+1 reflects FSM/counter values held after edge n (one-cycle latency).
REQ-023 duty=0 SHALL give led constantly 0; duty=2^PWM_W-1 SHALL give led 1 for 2^PWM_W-1 of every 2^PWM_W cycles.
REQ-024 mode_q SHALL change on the same edge as the FSM transition.
REQ-025 tick=0 SHALL freeze blink_cnt, blink_state, duty and FSM state; only pwm_cnt and led update.

Reset
REQ-026 rst=1 at an edge SHALL force: FSM S_OFF, pending mode 00, mode_q 00, led 0, pwm_cnt 0, duty 0, blink_cnt 0, blink_state 0.
REQ-027 rst SHALL take priority over tick and mode_load in the same cycle; reset mid-pattern SHALL discard all pattern progress.
REQ-028 The first tick after reset release with pending 00 SHALL leave the block in S_OFF.

Verification
REQ-029 Reset, load mode=01, tick once -> mode_q=01 same edge, led=1 from next edge, holds with no further ticks.
REQ-030 BLINK_TICKS=4, load 10, tick each 10 cycles -> led 1 for ticks 1-4, 0 for ticks 5-8, 1 again at tick 9; no change between ticks.
REQ-031 PWM_W=8, load 11, apply 255 ticks -> duty=255, S_UP; tick 256 -> duty 255, S_DN; tick 257 -> duty 254; measured led duty over 256 cycles at duty=128 equals 128.
REQ-032 In BLINK, mode_load=1 with mode=10 on a tick cycle -> no restart, blink_cnt continues; mode_load=1 mode=11 on a tick cycle -> enters S_UP that edge, duty=0, led 0.
REQ-033 In BREATHE at duty=100, assert rst with tick=1 and mode_load=1 -> next edge all outputs 0, mode_q=00; subsequent tick stays S_OFF.
REQ-034 Load mode=01 with tick=0 for 50 cycles -> mode_q stays 00 and led 0 until first tick.
